// File: rtl/tlc_input_conditioner.sv
// rtl/tlc_input_conditioner.sv - synchronize, debounce and arbitrate tail-light switch inputs
module tlc_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic brake_sw,
  input  logic turn_right_sw,
  input  logic turn_left_sw,
  output logic brake,
  output logic turn_right,
  output logic turn_left,
  output logic sw_fault
);

  // Channel index: 0 = brake, 1 = right turn, 2 = left turn
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RIGHT    = 2'd1,
    ST_LEFT     = 2'd2,
    ST_CONFLICT = 2'd3
  } state_t;

  logic [2:0] raw_sw;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [2:0] stable_q, stable_d;
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  state_t state_q, state_d;
  logic   brake_q, brake_d;
  logic   turn_right_q, turn_right_d;
  logic   turn_left_q, turn_left_d;
  logic   sw_fault_q, sw_fault_d;

  assign raw_sw = {turn_left_sw, turn_right_sw, brake_sw};

  // Two-flop synchronizer plus per-channel debounce: a change is accepted only
  // after sync2 has differed from stable for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    sync1_d  = raw_sw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Synchronizer, counter and stable-bit registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 3'b000;
      sync2_q  <= 3'b000;
      stable_q <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= 8'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Turn arbitration next state; an active direction holds until its own switch drops
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (stable_q[1] && stable_q[2])       state_d = ST_CONFLICT;
        else if (stable_q[1])                 state_d = ST_RIGHT;
        else if (stable_q[2])                 state_d = ST_LEFT;
      end
      ST_RIGHT:    if (!stable_q[1])                 state_d = ST_IDLE;
      ST_LEFT:     if (!stable_q[2])                 state_d = ST_IDLE;
      ST_CONFLICT: if (!stable_q[1] && !stable_q[2]) state_d = ST_IDLE;
      default:                                       state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state so they register alongside it
  always_comb begin
    brake_d      = stable_q[0];
    turn_right_d = (state_d == ST_RIGHT);
    turn_left_d  = (state_d == ST_LEFT);
    sw_fault_d   = (state_d == ST_CONFLICT);
  end

  // FSM state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      brake_q      <= 1'b0;
      turn_right_q <= 1'b0;
      turn_left_q  <= 1'b0;
      sw_fault_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      brake_q      <= brake_d;
      turn_right_q <= turn_right_d;
      turn_left_q  <= turn_left_d;
      sw_fault_q   <= sw_fault_d;
    end
  end

  assign brake      = brake_q;
  assign turn_right = turn_right_q;
  assign turn_left  = turn_left_q;
  assign sw_fault   = sw_fault_q;

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// tb/tb_tlc_input_conditioner.sv - directed self-checking bench for tlc_input_conditioner
module tb_tlc_input_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  logic brake_sw, turn_right_sw, turn_left_sw;
  logic brake, turn_right, turn_left, sw_fault;

  int vectors = 0;
  int miscompares = 0;

  tlc_input_conditioner #(.DEBOUNCE_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .brake_sw     (brake_sw),
    .turn_right_sw(turn_right_sw),
    .turn_left_sw (turn_left_sw),
    .brake        (brake),
    .turn_right   (turn_right),
    .turn_left    (turn_left),
    .sw_fault     (sw_fault)
  );

  always #5 clk = ~clk;

  // advance n rising edges, ending 1 time unit after the last one
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // outputs packed as {brake, turn_right, turn_left, sw_fault}
  function automatic logic [7:0] outs();
    return {4'b0000, brake, turn_right, turn_left, sw_fault};
  endfunction

  initial begin
    rst_n = 1'b0;
    brake_sw = 1'b0;
    turn_right_sw = 1'b0;
    turn_left_sw = 1'b0;
    tick(3);
    check("reset_outputs", outs(), 8'h00);
    check("reset_cnt_r", dut.cnt_q[1], 8'h00);
    rst_n = 1'b1;
    tick(3);
    check("idle_outputs", outs(), 8'h00);

    // brake rise: accepted on edge 11, not edge 10
    brake_sw = 1'b1;
    tick(10);
    check("brake_edge10", outs(), 8'h00);
    tick(1);
    check("brake_edge11", outs(), 8'h08);
    brake_sw = 1'b0;
    tick(10);
    check("brake_fall_edge10", outs(), 8'h08);
    tick(1);
    check("brake_fall_edge11", outs(), 8'h00);

    // 5-cycle glitch on right turn is rejected, counter returns to 0
    turn_right_sw = 1'b1;
    tick(5);
    turn_right_sw = 1'b0;
    tick(12);
    check("glitch_no_turn", outs(), 8'h00);
    check("glitch_cnt_zero", dut.cnt_q[1], 8'h00);

    // bounce 1/0 every 3 cycles for 30 cycles, then hold high
    for (int p = 0; p < 10; p++) begin
      turn_right_sw = (p % 2 == 0);
      tick(3);
      check("bounce_no_turn", outs(), 8'h00);
    end
    turn_right_sw = 1'b1;
    tick(10);
    check("bounce_edge10", outs(), 8'h00);
    tick(1);
    check("bounce_edge11", outs(), 8'h04);

    // left raised while right active is ignored
    turn_left_sw = 1'b1;
    tick(15);
    check("right_holds", outs(), 8'h04);
    // release right: IDLE for one cycle, then LEFT
    turn_right_sw = 1'b0;
    tick(10);
    check("rel_right_edge10", outs(), 8'h04);
    tick(1);
    check("rel_right_idle", outs(), 8'h00);
    tick(1);
    check("left_after_idle", outs(), 8'h02);
    turn_left_sw = 1'b0;
    tick(11);
    check("left_released", outs(), 8'h00);

    // both raised together -> conflict after 11 edges
    turn_right_sw = 1'b1;
    turn_left_sw = 1'b1;
    tick(10);
    check("conflict_edge10", outs(), 8'h00);
    tick(1);
    check("conflict_edge11", outs(), 8'h01);
    turn_right_sw = 1'b0;
    turn_left_sw = 1'b0;
    tick(10);
    check("conflict_rel_edge10", outs(), 8'h01);
    tick(1);
    check("conflict_rel_edge11", outs(), 8'h00);

    // async reset while brake and left active, then reacquire
    brake_sw = 1'b1;
    turn_left_sw = 1'b1;
    tick(11);
    check("pre_reset_active", outs(), 8'h0A);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", outs(), 8'h00);
    check("async_reset_stable", {5'b0, dut.stable_q}, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("post_reset_edge10", outs(), 8'h00);
    tick(1);
    check("post_reset_edge11", outs(), 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
